// File: rtl/fifo_word_packer.sv
// Purpose: read-side drain behind the async fifo; packs LANES byte lanes into one wide word.
// Latency: a word appears LANES+1 cycles after its first read_en; steady state is one word per LANES+1 cycles.
// Backpressure: m_ready low holds the output word; assembly fills up to LANES and then read_en drops.
//
// Ports:
//   read_clk   clock shared with the fifo read side
//   reset      synchronous, active-high
//   mem_empty  fifo empty flag
//   fifo_data  fifo read data, valid the cycle after read_en
//   read_en    fifo pop request (combinational)
//   flush      single-cycle pulse: emit whatever is assembled as a last word
//   m_valid    output word valid; m_ready is the downstream accept
//   m_data     packed word, lane k at [k*DATA_W +: DATA_W]
//   m_count    number of valid lanes (1..LANES)
//   m_last     word was produced by a flush
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,            // legal range 2..8
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic                      read_clk,
  input  logic                      reset,
  input  logic                      mem_empty,
  input  logic [DATA_W-1:0]         fifo_data,
  output logic                      read_en,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W*LANES-1:0]   m_data,
  output logic [CNT_W-1:0]          m_count,
  output logic                      m_last
);

  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  logic [DATA_W*LANES-1:0] asm_q;
  logic [DATA_W*LANES-1:0] asm_nxt;
  logic [CNT_W-1:0]        fill;
  logic [CNT_W-1:0]        fill_nxt;
  logic                    inflight;
  logic                    flush_pend;
  logic                    slot_free;
  logic                    full_xfer;
  logic                    flush_xfer;
  logic                    flush_drop;
  logic                    do_xfer;

  // Lanes that will be occupied once the byte currently on fifo_data lands.
  assign fill_nxt = fill + {{(CNT_W-1){1'b0}}, inflight};

  // Counting the in-flight byte against the lane budget guarantees a popped
  // byte always has a lane to land in, so no overflow path exists.
  assign read_en = !reset && !mem_empty && !flush_pend && !flush && (fill_nxt < LANES_C);

  assign slot_free = !m_valid || m_ready;

  // The transfer looks at the post-capture view, so the last lane leaves on
  // the same edge it is captured. This keeps the stream at LANES+1 cycles per
  // word instead of paying an extra cycle to let fill settle.
  assign full_xfer = (fill_nxt == LANES_C);

  // A pending flush can never coexist with a byte in flight (read_en is held
  // low in the flush cycle), but the inflight term keeps the intent explicit.
  assign flush_xfer = flush_pend && !inflight && (fill != '0);
  assign flush_drop = flush_pend && !inflight && (fill == '0);

  assign do_xfer = slot_free && (full_xfer || flush_xfer);

  always_comb begin
    asm_nxt = asm_q;
    for (int k = 0; k < LANES; k++) begin
      if (inflight && (fill == CNT_W'(k))) begin
        asm_nxt[k*DATA_W +: DATA_W] = fifo_data;
      end
    end
  end

  always_ff @(posedge read_clk) begin
    if (reset) begin
      // A byte popped before reset is dropped here; the fifo pointer has
      // already moved past it.
      asm_q      <= '0;
      fill       <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_count    <= '0;
      m_last     <= 1'b0;
    end else begin
      inflight <= read_en;

      if (do_xfer) begin
        // Unused lanes are already zero because asm is cleared on every
        // transfer, so a partial word needs no masking.
        m_data  <= asm_nxt;
        m_count <= fill_nxt;
        m_last  <= flush_pend;
        m_valid <= 1'b1;
        fill    <= '0;
        asm_q   <= '0;
      end else begin
        fill  <= fill_nxt;
        asm_q <= asm_nxt;
        if (m_ready) begin
          m_valid <= 1'b0;
        end
      end

      // A second flush while one is pending is absorbed.
      if (flush_pend) begin
        if (do_xfer || flush_drop) begin
          flush_pend <= 1'b0;
        end
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

  logic        read_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        flush    = 1'b0;
  logic        m_ready  = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        mem_empty;
  logic        read_en;
  logic        m_valid;
  logic [31:0] m_data;
  logic [2:0]  m_count;
  logic        m_last;

  always #5 read_clk = ~read_clk;

  fifo_word_packer dut (
    .read_clk  (read_clk),
    .reset     (reset),
    .mem_empty (mem_empty),
    .fifo_data (fifo_data),
    .read_en   (read_en),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_count   (m_count),
    .m_last    (m_last)
  );

  // Behavioural fifo read side: one-cycle registered read latency.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign mem_empty = (wr_ptr == rd_ptr);

  int         cyc = 0;
  logic [7:0] rd_cnt = 8'd0;
  int         re_cyc [0:255];
  bit         re_s = 1'b0;

  logic [31:0] out_dat  [0:255];
  logic [2:0]  out_cnt  [0:255];
  logic        out_last [0:255];
  int          out_cyc  [0:255];
  logic [7:0]  nw = 8'd0;

  int checks = 0;
  int errors = 0;

  // Inputs only change just after posedge, so negedge values are what the
  // next edge will see.
  always @(negedge read_clk) begin
    re_s = read_en;
    if (m_valid && m_ready) begin
      out_dat[nw]  = m_data;
      out_cnt[nw]  = m_count;
      out_last[nw] = m_last;
      out_cyc[nw]  = cyc;
      nw = nw + 8'd1;
    end
  end

  always @(posedge read_clk) begin
    if (re_s) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
      re_cyc[rd_cnt] = cyc;
      rd_cnt = rd_cnt + 8'd1;
    end
    cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_words(input logic [7:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (nw >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (nw >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b expected 0", read_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h expected 00000000", m_data); end
    checks++; if (m_count !== 3'd0) begin errors++; $display("FAIL reset_m_count: got %0d expected 0", m_count); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
  endtask

  task automatic test_basic();
    logic [7:0] r0, w0, idx;
    bit ok;
    r0 = rd_cnt; w0 = nw;
    for (int i = 0; i < 8; i++) push(8'(17 * (i + 1)));
    tick(); tick();
    checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL reset_override_read_en: got %b expected 0", read_en); end
    checks++; if (rd_cnt !== r0) begin errors++; $display("FAIL reset_override_pops: got %0d expected %0d", rd_cnt, r0); end
    reset = 1'b0;
    wait_words(w0 + 8'd2, 60, ok);
    repeat (5) tick();
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d words expected 2", nw - w0); end
    idx = w0;
    checks++; if (out_dat[idx] !== 32'h44332211) begin errors++; $display("FAIL basic_word0: got %h expected 44332211", out_dat[idx]); end
    checks++; if (out_cnt[idx] !== 3'd4) begin errors++; $display("FAIL basic_count0: got %0d expected 4", out_cnt[idx]); end
    checks++; if (out_last[idx] !== 1'b0) begin errors++; $display("FAIL basic_last0: got %b expected 0", out_last[idx]); end
    idx = w0 + 8'd1;
    checks++; if (out_dat[idx] !== 32'h88776655) begin errors++; $display("FAIL basic_word1: got %h expected 88776655", out_dat[idx]); end
    checks++; if (out_cnt[idx] !== 3'd4) begin errors++; $display("FAIL basic_count1: got %0d expected 4", out_cnt[idx]); end
    checks++; if (out_last[idx] !== 1'b0) begin errors++; $display("FAIL basic_last1: got %b expected 0", out_last[idx]); end
    checks++; if (rd_cnt - r0 !== 8'd8) begin errors++; $display("FAIL basic_pops: got %0d expected 8", rd_cnt - r0); end
    checks++; if (nw - w0 !== 8'd2) begin errors++; $display("FAIL basic_words: got %0d expected 2", nw - w0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] r0, w0, idx;
    bit ok;
    r0 = rd_cnt; w0 = nw;
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(i + 1));
    repeat (20) tick();
    // One word parked in the output register plus a full assembly register.
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 32'h04030201) begin errors++; $display("FAIL bp_hold_data: got %h expected 04030201", m_data); end
    checks++; if (m_count !== 3'd4) begin errors++; $display("FAIL bp_hold_count: got %0d expected 4", m_count); end
    checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL bp_read_en: got %b expected 0", read_en); end
    checks++; if (rd_cnt - r0 !== 8'd8) begin errors++; $display("FAIL bp_pops: got %0d expected 8", rd_cnt - r0); end
    checks++; if (nw !== w0) begin errors++; $display("FAIL bp_no_accept: got %0d words expected 0", nw - w0); end
    repeat (5) tick();
    checks++; if (m_data !== 32'h04030201) begin errors++; $display("FAIL bp_stable_data: got %h expected 04030201", m_data); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_stable_valid: got %b expected 1", m_valid); end
    m_ready = 1'b1;
    wait_words(w0 + 8'd3, 40, ok);
    repeat (6) tick();
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d words expected 3", nw - w0); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp;
      for (int j = 0; j < 4; j++) exp[j*8 +: 8] = 8'(4 * k + j + 1);
      idx = w0 + 8'(k);
      checks++; if (out_dat[idx] !== exp) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", k, out_dat[idx], exp); end
    end
    checks++; if (nw - w0 !== 8'd3) begin errors++; $display("FAIL bp_words: got %0d expected 3", nw - w0); end
    checks++; if (rd_cnt - r0 !== 8'd12) begin errors++; $display("FAIL bp_total_pops: got %0d expected 12", rd_cnt - r0); end
  endtask

  task automatic test_flush();
    logic [7:0] w0, w1;
    bit ok;
    w0 = nw;
    push(8'hA1); push(8'hB2); push(8'hC3);
    repeat (10) tick();
    checks++; if (nw !== w0) begin errors++; $display("FAIL flush_no_early_word: got %0d words expected 0", nw - w0); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_partial_held: got %b expected 0", m_valid); end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_words(w0 + 8'd1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_timeout: got %0d words expected 1", nw - w0); end
    checks++; if (out_dat[w0] !== 32'h00C3B2A1) begin errors++; $display("FAIL flush_data: got %h expected 00c3b2a1", out_dat[w0]); end
    checks++; if (out_cnt[w0] !== 3'd3) begin errors++; $display("FAIL flush_count: got %0d expected 3", out_cnt[w0]); end
    checks++; if (out_last[w0] !== 1'b1) begin errors++; $display("FAIL flush_last: got %b expected 1", out_last[w0]); end
    repeat (3) tick();
    w1 = nw;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (6) tick();
    checks++; if (nw !== w1) begin errors++; $display("FAIL flush_empty_word: got %0d words expected 0", nw - w1); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid: got %b expected 0", m_valid); end
  endtask

  task automatic test_flush_inflight();
    logic [7:0] w0;
    bit ok;
    w0 = nw;
    push(8'h5A); push(8'h6B);
    tick();
    checks++; if (read_en !== 1'b1) begin errors++; $display("FAIL fi_second_pop: got %b expected 1", read_en); end
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_words(w0 + 8'd1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fi_timeout: got %0d words expected 1", nw - w0); end
    checks++; if (out_dat[w0] !== 32'h00006B5A) begin errors++; $display("FAIL fi_data: got %h expected 00006b5a", out_dat[w0]); end
    checks++; if (out_cnt[w0] !== 3'd2) begin errors++; $display("FAIL fi_count: got %0d expected 2", out_cnt[w0]); end
    checks++; if (out_last[w0] !== 1'b1) begin errors++; $display("FAIL fi_last: got %b expected 1", out_last[w0]); end
    repeat (3) tick();
  endtask

  task automatic test_reset_midword();
    logic [7:0] w0, w1;
    bit ok;
    w0 = nw;
    push(8'hE1); push(8'hE2); push(8'hE3);
    tick(); tick(); tick();
    // Two lanes captured, third byte on the fifo bus.
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rm_data: got %h expected 00000000", m_data); end
    checks++; if (m_count !== 3'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", m_count); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rm_last: got %b expected 0", m_last); end
    repeat (4) tick();
    checks++; if (nw !== w0) begin errors++; $display("FAIL rm_spurious: got %0d words expected 0", nw - w0); end
    w1 = nw;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    wait_words(w1 + 8'd1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout: got %0d words expected 1", nw - w1); end
    checks++; if (out_dat[w1] !== 32'h34333231) begin errors++; $display("FAIL rm_clean_word: got %h expected 34333231", out_dat[w1]); end
    checks++; if (out_cnt[w1] !== 3'd4) begin errors++; $display("FAIL rm_clean_count: got %0d expected 4", out_cnt[w1]); end
    checks++; if (out_last[w1] !== 1'b0) begin errors++; $display("FAIL rm_clean_last: got %b expected 0", out_last[w1]); end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, w0, idx, prv;
    bit ok;
    r0 = rd_cnt; w0 = nw;
    for (int i = 0; i < 40; i++) push(8'(i + 1));
    wait_words(w0 + 8'd10, 120, ok);
    repeat (4) tick();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d words expected 10", nw - w0); end
    checks++; if (nw - w0 !== 8'd10) begin errors++; $display("FAIL b2b_words: got %0d expected 10", nw - w0); end
    checks++; if (rd_cnt - r0 !== 8'd40) begin errors++; $display("FAIL b2b_pops: got %0d expected 40", rd_cnt - r0); end
    checks++; if (out_cyc[w0] - re_cyc[r0] !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", out_cyc[w0] - re_cyc[r0]); end
    for (int k = 0; k < 10; k++) begin
      logic [31:0] exp;
      for (int j = 0; j < 4; j++) exp[j*8 +: 8] = 8'(4 * k + j + 1);
      idx = w0 + 8'(k);
      checks++; if (out_dat[idx] !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", k, out_dat[idx], exp); end
      checks++; if (out_cnt[idx] !== 3'd4 || out_last[idx] !== 1'b0) begin errors++; $display("FAIL b2b_meta%0d: got count %0d last %b expected 4 0", k, out_cnt[idx], out_last[idx]); end
      if (k > 0) begin
        prv = idx - 8'd1;
        checks++; if (out_cyc[idx] - out_cyc[prv] !== 5) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 5", k, out_cyc[idx] - out_cyc[prv]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_inflight();
    test_reset_midword();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
